// File: rtl/psk_diff_decode_if.sv
// AXIS-style stream bundle used on both sides of the differential decoder.
interface psk_diff_decode_if #(
  parameter int BYTES = 1
);
  logic [BYTES*8-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic               tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/psk_diff_decode.sv
// Differential BPSK/QPSK phase decoder: output is the phase step between consecutive symbols of a packet.
// Optional PSK_DIFF_DECODE_GRAY_EN: QPSK phase indices are Gray-coded on input and output.
module psk_diff_decode #(
  parameter int BYTES = 1
) (
  input  logic            clk,
  input  logic            rst,
  psk_diff_decode_if.slave  sym,
  psk_diff_decode_if.master decoded
);
  localparam int W = BYTES * 8;

  typedef enum logic { S_HEAD, S_BODY } state_t;

  typedef struct packed {
    logic [1:0] d;
    logic       last;
    logic       user;
  } beat_t;

  state_t     state_q, state_d;
  logic       bpsk_q, bpsk_d;
  logic [1:0] ref_q, ref_d;
  beat_t      beat, out_q, skid_q;
  logic       out_vld, skid_vld;
  logic       accept, head, bpsk;
  logic [1:0] cur, cur_b, ref_use, diff, next_ref;
  logic       unused_tdata;

`ifdef PSK_DIFF_DECODE_GRAY_EN
  function automatic logic [1:0] g2b(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction
  function automatic logic [1:0] b2g(input logic [1:0] b);
    return {b[1], b[1] ^ b[0]};
  endfunction
`endif

  assign sym.tready   = !rst && !skid_vld;
  assign accept       = sym.tvalid && sym.tready;
  assign cur          = sym.tdata[1:0];
  assign unused_tdata = ^sym.tdata[W-1:2];

  always_comb begin
    state_d  = state_q;
    bpsk_d   = bpsk_q;
    ref_d    = ref_q;
    head     = (state_q == S_HEAD);
    // Packet heads always decode against phase 0 with the head's own mode.
    bpsk     = head ? sym.tuser : bpsk_q;
    ref_use  = head ? 2'b00 : ref_q;
`ifdef PSK_DIFF_DECODE_GRAY_EN
    cur_b    = g2b(cur);
`else
    cur_b    = cur;
`endif
    diff     = cur_b - ref_use;
    beat     = '0;
    next_ref = cur_b;
    if (bpsk) begin
      beat.d   = {cur[1] ^ ref_use[1], 1'b0};
      next_ref = {cur[1], 1'b0};
    end else begin
`ifdef PSK_DIFF_DECODE_GRAY_EN
      beat.d = b2g(diff);
`else
      beat.d = diff;
`endif
    end
    beat.last = sym.tlast;
    beat.user = bpsk;
    if (accept) begin
      bpsk_d  = bpsk;
      ref_d   = next_ref;
      state_d = sym.tlast ? S_HEAD : S_BODY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HEAD;
      bpsk_q  <= 1'b0;
      ref_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      bpsk_q  <= bpsk_d;
      ref_q   <= ref_d;
    end
  end

  // Output register with one-entry skid; skid only fills when the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (!out_vld || decoded.tready) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_q   <= beat;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= beat;
      skid_vld <= 1'b1;
    end
  end

  assign decoded.tvalid = out_vld;
  assign decoded.tdata  = {{(W-2){1'b0}}, out_q.d};
  assign decoded.tlast  = out_q.last;
  assign decoded.tuser  = out_q.user;
endmodule

// File: tb/tb_psk_diff_decode.sv
// Directed bench for psk_diff_decode: hand-computed beats compared against a collected output log.
module tb_psk_diff_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  psk_diff_decode_if #(.BYTES(1)) sym_if ();
  psk_diff_decode_if #(.BYTES(1)) dec_if ();

  psk_diff_decode #(.BYTES(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .sym     (sym_if),
    .decoded (dec_if)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge sees the values the next posedge will use.
  always @(negedge clk) begin
    if (dec_if.tvalid && dec_if.tready)
      got_q.push_back({dec_if.tuser, dec_if.tlast, dec_if.tdata});
    if (sym_if.tvalid && sym_if.tready)
      acc_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic u);
    sym_if.tdata  = d;
    sym_if.tlast  = l;
    sym_if.tuser  = u;
    sym_if.tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sym_if.tready) begin
        @(posedge clk); #1;
        sym_if.tvalid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    sym_if.tvalid = 1'b0;
  endtask

  task automatic ex(input logic u, input logic l, input logic [7:0] d);
    exp_q.push_back({u, l, d});
  endtask

  task automatic check_q(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < 50 && got_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_q.size())
        chk($sformatf("%s_%0d", tag, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    sym_if.tdata  = '0;
    sym_if.tvalid = 1'b0;
    sym_if.tlast  = 1'b0;
    sym_if.tuser  = 1'b0;
    dec_if.tready = 1'b1;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", dec_if.tvalid, 0);
    chk("rst_tdata", dec_if.tdata, 0);
    chk("rst_tlast", dec_if.tlast, 0);
    chk("rst_tuser", dec_if.tuser, 0);
    chk("rst_tready", sym_if.tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef PSK_DIFF_DECODE_GRAY_EN
    // Gray 0,1,3,2 -> binary 0,1,2,3 -> d 0,1,1,1 -> Gray 0,1,1,1.
    send(8'd0, 0, 0); send(8'd1, 0, 0); send(8'd3, 0, 0); send(8'd2, 1, 0);
    ex(0, 0, 8'd0); ex(0, 0, 8'd1); ex(0, 0, 8'd1); ex(0, 1, 8'd1);
    check_q("gray");
`else
    // QPSK 1,3,0,2 -> 1,2,1,2 with one-cycle latency.
    send(8'd1, 0, 0);
    chk("lat_tvalid", dec_if.tvalid, 1);
    chk("lat_tdata", dec_if.tdata, 1);
    send(8'd3, 0, 0); send(8'd0, 0, 0); send(8'd2, 1, 0);
    ex(0, 0, 8'd1); ex(0, 0, 8'd2); ex(0, 0, 8'd1); ex(0, 1, 8'd2);
    check_q("qpsk");

    // Back-to-back packets, each head against 0.
    send(8'd3, 1, 0); send(8'd3, 0, 0); send(8'd3, 1, 0);
    ex(0, 1, 8'd3); ex(0, 0, 8'd3); ex(0, 1, 8'd0);
    check_q("b2b");

    // Idle gap mid-packet holds ref and state.
    send(8'd1, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    send(8'd3, 1, 0);
    ex(0, 0, 8'd1); ex(0, 1, 8'd2);
    check_q("gap");

    // Backpressure: 5-beat stream, output stalled 3 clocks.
    dec_if.tready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        send(8'd0, 0, 0); send(8'd1, 0, 0); send(8'd2, 0, 0);
        send(8'd3, 0, 0); send(8'd0, 1, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_accepts", acc_cnt, 2);
        chk("bp_tready", sym_if.tready, 0);
        chk("bp_hold", {dec_if.tvalid, dec_if.tdata}, {1'b1, 8'd0});
        dec_if.tready = 1'b1;
      end
    join
    ex(0, 0, 8'd0); ex(0, 0, 8'd1); ex(0, 0, 8'd1); ex(0, 0, 8'd1); ex(0, 1, 8'd1);
    check_q("bp");

    // Reset mid-packet: next beat is a head.
    send(8'd1, 0, 0); send(8'd2, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_tvalid", dec_if.tvalid, 0);
    chk("mrst_tready", sym_if.tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    send(8'd2, 1, 0);
    ex(0, 1, 8'd2);
    check_q("mrst");
`endif

    // BPSK: bit1 = 1,1,0,0 with bit0 noise; tuser only honoured at head.
    send(8'd3, 0, 1); send(8'd3, 0, 0); send(8'd1, 0, 0); send(8'd1, 1, 0);
    ex(1, 0, 8'd2); ex(1, 0, 8'd0); ex(1, 0, 8'd2); ex(1, 1, 8'd0);
    check_q("bpsk");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
